// File: rtl/bpsk_tx_pkg.sv
// Shared types and defaults for the BPSK transmit frame scheduler.
package bpsk_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    GUARD
  } tx_state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hF3A5;
  localparam int          SPS_DEFAULT       = 20;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bpsk_sym_timer.sv
// Per-symbol sample counter. 'run' says whether the coming clock belongs to a
// symbol, so sym_start is a flop that lines up with the first clock of a symbol.
module bpsk_sym_timer
  import bpsk_tx_pkg::*;
#(
  parameter int SPS = SPS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sym_start,
  output logic sym_end,
  output logic sym_pre_end
);

  localparam int            CW   = $clog2(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] PRE  = CW'(SPS - 2);

  logic [CW-1:0] cnt_reg;
  logic          active_reg;
  logic          start_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      start_reg  <= 1'b0;
    end else if (!run) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      start_reg  <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      // A new symbol begins either from rest or right after the last sample.
      if (!active_reg || cnt_reg == LAST) begin
        cnt_reg   <= '0;
        start_reg <= 1'b1;
      end else begin
        cnt_reg   <= cnt_reg + 1'b1;
        start_reg <= 1'b0;
      end
    end
  end

  assign sym_start   = start_reg;
  assign sym_end     = active_reg && (cnt_reg == LAST);
  assign sym_pre_end = active_reg && (cnt_reg == PRE);

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Frames payload bytes as preamble / sync word / payload / guard and serialises
// them MSB-first into the modulator's en/in inputs, one symbol per SPS clocks.
module bpsk_tx_scheduler
  import bpsk_tx_pkg::*;
#(
  parameter int          SPS           = SPS_DEFAULT,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int          GUARD_SYMS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       mod_en,
  output logic       mod_bit,
  output logic       sym_tick,
  output logic       busy,
  output logic       underrun
);

  localparam int               IDX_W      = $clog2(max_of4(PREAMBLE_BITS, 16, 8, GUARD_SYMS));
  localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0] SYNC_LAST  = IDX_W'(15);
  localparam logic [IDX_W-1:0] BYTE_LAST  = IDX_W'(7);
  localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_SYMS - 1);

  tx_state_t        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             last_reg, last_next;
  logic             mod_bit_reg, mod_bit_next;
  logic             s_ready_reg, s_ready_next;
  logic             underrun_reg, underrun_next;
  logic             mod_en_reg, busy_reg;
  logic             sym_end, sym_pre_end, sym_start;
  logic             run, accept;
  logic [15:0]      sync_sh;

  assign run    = (state_next != IDLE);
  assign accept = s_valid && s_ready_reg;

  bpsk_sym_timer #(.SPS(SPS)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sym_start   (sym_start),
    .sym_end     (sym_end),
    .sym_pre_end (sym_pre_end)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    last_next     = last_reg;
    underrun_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          state_next = PREAMBLE;
          idx_next   = '0;
        end
      end
      PREAMBLE: begin
        if (sym_end) begin
          if (idx_reg == PRE_LAST) begin
            state_next = SYNC;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      SYNC, PAYLOAD: begin
        if (sym_end) begin
          if ((state_reg == SYNC && idx_reg == SYNC_LAST) ||
              (state_reg == PAYLOAD && idx_reg == BYTE_LAST)) begin
            idx_next = '0;
            if (state_reg == PAYLOAD && last_reg) begin
              state_next = GUARD;
            end else if (accept) begin
              state_next = PAYLOAD;
              shift_next = s_data;
              last_next  = s_last;
            end else begin
              state_next    = GUARD;
              underrun_next = 1'b1;
            end
          end else begin
            idx_next = idx_reg + 1'b1;
            if (state_reg == PAYLOAD) shift_next = {shift_reg[6:0], 1'b0};
          end
        end
      end
      GUARD: begin
        if (sym_end) begin
          if (idx_reg == GUARD_LAST) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The bit for the upcoming symbol is chosen only when a symbol boundary is crossed.
  assign sync_sh = SYNC_WORD << idx_next;

  always_comb begin
    mod_bit_next = mod_bit_reg;
    if (state_reg == IDLE || sym_end) begin
      case (state_next)
        PREAMBLE: mod_bit_next = ~idx_next[0];
        SYNC:     mod_bit_next = sync_sh[15];
        PAYLOAD:  mod_bit_next = shift_next[7];
        default:  mod_bit_next = 1'b0;
      endcase
    end
    // Registered ready: raised one clock ahead so it lands on the symbol's final clock.
    s_ready_next = sym_pre_end &&
                   ((state_reg == SYNC && idx_reg == SYNC_LAST) ||
                    (state_reg == PAYLOAD && idx_reg == BYTE_LAST && !last_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      shift_reg    <= '0;
      last_reg     <= 1'b0;
      mod_bit_reg  <= 1'b0;
      s_ready_reg  <= 1'b0;
      underrun_reg <= 1'b0;
      mod_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      last_reg     <= last_next;
      mod_bit_reg  <= mod_bit_next;
      s_ready_reg  <= s_ready_next;
      underrun_reg <= underrun_next;
      mod_en_reg   <= (state_next != IDLE);
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign s_ready  = s_ready_reg;
  assign mod_en   = mod_en_reg;
  assign mod_bit  = mod_bit_reg;
  assign sym_tick = sym_start;
  assign busy     = busy_reg;
  assign underrun = underrun_reg;

endmodule
